// File: rtl/issue_prf_wb_arbiter.sv
// issue_prf_wb_arbiter
//   Round-robin writeback arbiter in front of a single PRF write port, plus
//   the physical-register ready bitmap used by issue.
//
//   Ports
//     clk, reset        : clock, synchronous active-low reset
//     req_valid/ready   : per-requester (3) writeback handshake, ready is comb
//     req_addr/req_data : packed per-requester destination and data
//     alloc_valid/addr  : rename allocation, clears the ready bit
//     prf_addra/wea/dina: registered PRF write port (one cycle after grant)
//     prf_ready         : one bit per physical register, 1 = value final
module issue_prf_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                req_valid,
  output logic [2:0]                req_ready,
  input  logic [3*ADDR_WIDTH-1:0]   req_addr,
  input  logic [3*DATA_WIDTH-1:0]   req_data,
  input  logic                      alloc_valid,
  input  logic [ADDR_WIDTH-1:0]     alloc_addr,
  output logic [ADDR_WIDTH-1:0]     prf_addra,
  output logic                      prf_wea,
  output logic [DATA_WIDTH-1:0]     prf_dina,
  output logic [2**ADDR_WIDTH-1:0]  prf_ready
);

  localparam int NUM_REQ  = 3;
  localparam int NUM_PREG = 2**ADDR_WIDTH;

  logic [1:0]            rr_ptr;
  logic [1:0]            next_ptr;
  logic [NUM_REQ-1:0]    grant;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_PREG-1:0]   set_mask;
  logic [NUM_PREG-1:0]   clr_mask;

  // First valid requester starting at rr_ptr. Encoding 3 is unreachable and
  // falls back to requester-0 priority. Nothing is granted while in reset so
  // an in-flight handshake is dropped.
  always_comb begin
    grant = '0;
    case (rr_ptr)
      2'd1: begin
        if      (req_valid[1]) grant = 3'b010;
        else if (req_valid[2]) grant = 3'b100;
        else if (req_valid[0]) grant = 3'b001;
      end
      2'd2: begin
        if      (req_valid[2]) grant = 3'b100;
        else if (req_valid[0]) grant = 3'b001;
        else if (req_valid[1]) grant = 3'b010;
      end
      default: begin
        if      (req_valid[0]) grant = 3'b001;
        else if (req_valid[1]) grant = 3'b010;
        else if (req_valid[2]) grant = 3'b100;
      end
    endcase
    if (!reset) grant = '0;
  end

  assign req_ready = grant;
  assign hs        = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    next_ptr = 2'd0;
    if (grant[0])      next_ptr = 2'd1;
    else if (grant[1]) next_ptr = 2'd2;
  end

  // The ready bit is raised on the grant edge (so issue sees it alongside
  // prf_wea) and raised again on the edge the PRF actually takes the write.
  // The second set lets an allocation of the same register in the write
  // cycle lose to the write, since set beats clear on any shared edge.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (hs)          set_mask[sel_addr]   = 1'b1;
    if (prf_wea)     set_mask[prf_addra]  = 1'b1;
    if (alloc_valid) clr_mask[alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr    <= 2'd0;
      prf_wea   <= 1'b0;
      prf_addra <= '0;
      prf_dina  <= '0;
      prf_ready <= '1;
    end else begin
      prf_wea   <= hs;
      prf_ready <= (prf_ready & ~clr_mask) | set_mask;
      if (hs) begin
        rr_ptr    <= next_ptr;
        prf_addra <= sel_addr;
        prf_dina  <= sel_data;
      end
    end
  end

endmodule

// File: doc/issue_prf_wb_arbiter.md
ISSUE_PRF_WB_ARBITER -- requirements
Module: issue_prf_wb_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 64, PRF write-data width.
REQ-002 Parameter: ADDR_WIDTH, 6, PRF address width; the ready bitmap is 2**ADDR_WIDTH bits wide.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 req_valid  input  3  per-requester writeback request (bit i = requester i).
REQ-006 req_ready  output  3  per-requester grant; a handshake for requester i occurs when req_valid[i] and req_ready[i] are both 1.
REQ-007 req_addr  input  3*ADDR_WIDTH  destination physical register; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 req_data  input  3*DATA_WIDTH  writeback data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 alloc_valid  input  1  rename stage allocates a physical register this cycle.
REQ-010 alloc_addr  input  ADDR_WIDTH  physical register being allocated.
REQ-011 prf_addra  output  ADDR_WIDTH  PRF write-port address.
REQ-012 prf_wea  output  1  PRF write-port write enable.
REQ-013 prf_dina  output  DATA_WIDTH  PRF write-port data.
REQ-014 prf_ready  output  2**ADDR_WIDTH  bit p = 1 when physical register p holds its final value.

Function
REQ-015 The block SHALL keep a 2-bit round-robin pointer rr_ptr with legal values 0..2.
REQ-016 Grant: select the first requester i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
REQ-017 req_ready SHALL be combinational and one-hot; it SHALL be 3'b000 when no req_valid bit is set.
REQ-018 A requester whose req_valid is 1 and which is not granted SHALL hold req_valid, req_addr and req_data stable; the block SHALL NOT latch non-granted requests.
REQ-019 After a handshake with requester g, rr_ptr SHALL become (g+1) mod 3 at the next edge; with no handshake, rr_ptr SHALL hold.
REQ-020 Write latency: for a handshake in cycle N, prf_wea=1 in cycle N+1, with prf_addra and prf_dina taken from the granted requester's fields in cycle N.
REQ-021 In any cycle after a cycle with no handshake, prf_wea SHALL be 0 and prf_addra/prf_dina SHALL hold their previous values.
REQ-022 At most one PRF write SHALL occur per cycle; sustained throughput SHALL be one write per cycle.
REQ-023 Bitmap set: on the edge that registers a write to address p (end of cycle N), prf_ready[p] SHALL become 1, i.e. visible in cycle N+1 together with prf_wea.
REQ-024 Bitmap clear: alloc_valid=1 with alloc_addr=p SHALL clear prf_ready[p] at the next edge.
REQ-025 If, on the same edge, an allocation clears and a write sets the same address, the set SHALL win (prf_ready[p]=1).
REQ-026 Set and clear on different addresses in the same cycle SHALL both take effect.
REQ-027 Repeated writes or repeated allocations to the same address SHALL be idempotent on the bitmap.
REQ-028 Two requesters may target the same address; they SHALL be served in grant order, and the later write SHALL overwrite the earlier one.

Reset
REQ-029 While reset=0 at a rising edge, the block SHALL set: rr_ptr=0, prf_wea=0, prf_addra=0, prf_dina=0, prf_ready all ones.
REQ-030 While reset=0, req_ready SHALL be 3'b000, and no handshake SHALL be recognised.
REQ-031 A handshake in progress when reset is asserted SHALL be discarded: no PRF write SHALL follow it.
REQ-032 In the first cycle after reset is released, arbitration SHALL start from requester 0.

Verification
REQ-033 Reset release, req_valid=3'b111 held for 6 cycles -> req_ready sequence 001,010,100,001,010,100; prf_wea=1 from the 2nd through the 7th cycle.
REQ-034 alloc p=5 in cycle 0, then requester 1 writes addr 5, data 0xDEAD in cycle 2 -> prf_ready[5]=0 in cycles 1-2, 1 in cycle 3; prf_addra=5, prf_dina=0xDEAD, prf_wea=1 in cycle 3.
REQ-035 Same-edge conflict: alloc_valid with alloc_addr=9 in the cycle after the handshake for a write to 9 -> prf_ready[9]=1 after that edge.
REQ-036 Only requester 2 valid, rr_ptr=0 -> req_ready=100 immediately; rr_ptr=0 afterwards, so requester 0 wins a subsequent 3'b011 request.
REQ-037 reset=0 asserted in the same cycle as a handshake with addr 3 -> prf_wea=0 in the next cycle; prf_ready all ones.
REQ-038 Idle (req_valid=0) for 4 cycles after a write of 0x1234 -> prf_wea=0 and prf_dina=0x1234 held throughout.
